// File: rtl/fpu_dispatcher.sv
// Dispatches one latched FP request (op + two operands) to unit `op` and returns its result.
// Latency: 3 cycles from the accept edge to out_stb, plus unit stall cycles; an illegal op answers after 1 cycle.
// Backpressure: one transaction in flight; in_ack stays low while busy, and the result is held until out_ack.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   op, in1, in2, in_stb/in_ack  request side; op, in1 and in2 are sampled only on the accept edge
//   out, out_err, out_stb/out_ack  response side; out_err flags an illegal op or a watchdog timeout
//   busy                         high whenever a transaction is in flight (SEND, WAIT, RESP)
//   u_in1, u_in2                 latched operands, broadcast to every unit
//   u_in1_stb/u_in1_ack, u_in2_stb/u_in2_ack  one-hot operand handshakes, one bit per unit
//   u_out, u_out_stb/u_out_ack   unit results (unit k at [k*WIDTH +: WIDTH]) and result handshake
module fpu_dispatcher #(
    parameter int WIDTH     = 32,
    parameter int NUM_UNITS = 9,
    parameter int OP_W      = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [OP_W-1:0]            op,
    input  logic [WIDTH-1:0]           in1,
    input  logic [WIDTH-1:0]           in2,
    input  logic                       in_stb,
    output logic                       in_ack,
    output logic [WIDTH-1:0]           out,
    output logic                       out_err,
    output logic                       out_stb,
    input  logic                       out_ack,
    output logic                       busy,
    output logic [WIDTH-1:0]           u_in1,
    output logic [WIDTH-1:0]           u_in2,
    output logic [NUM_UNITS-1:0]       u_in1_stb,
    output logic [NUM_UNITS-1:0]       u_in2_stb,
    input  logic [NUM_UNITS-1:0]       u_in1_ack,
    input  logic [NUM_UNITS-1:0]       u_in2_ack,
    input  logic [NUM_UNITS*WIDTH-1:0] u_out,
    input  logic [NUM_UNITS-1:0]       u_out_stb,
    output logic [NUM_UNITS-1:0]       u_out_ack
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least 1 bit wide.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]           state;
    logic [OP_W-1:0]      sel;
    logic                 p1;
    logic                 p2;
    logic [CNT_W-1:0]     cnt;

    logic [NUM_UNITS-1:0] sel_hot;
    logic [NUM_UNITS-1:0] op_hot;
    logic [WIDTH-1:0]     unit_res;
    logic                 ack1;
    logic                 ack2;
    logic                 res_vld;
    logic                 wd_hit;

    // One-hot decode of the latched select and of the incoming op. An op with
    // no matching unit decodes to all zeros, which is how illegal ops are found.
    always_comb begin
        sel_hot  = '0;
        op_hot   = '0;
        unit_res = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sel_hot[k] = (32'(sel) == 32'(k));
            op_hot[k]  = (32'(op) == 32'(k));
            if (sel_hot[k]) begin
                unit_res = u_out[k*WIDTH +: WIDTH];
            end
        end
    end

    assign ack1    = |(u_in1_ack & sel_hot);
    assign ack2    = |(u_in2_ack & sel_hot);
    assign res_vld = |(u_out_stb & sel_hot);
    assign wd_hit  = (TIMEOUT != 0) && (cnt == CNT_LIMIT);

    // All handshake outputs decode from state, so an asynchronous reset
    // clears them immediately without waiting for a clock edge.
    assign in_ack    = (state == IDLE) && in_stb;
    assign out_stb   = (state == RESP);
    assign busy      = (state != IDLE);
    assign u_in1_stb = (state == SEND && p1) ? sel_hot : '0;
    assign u_in2_stb = (state == SEND && p2) ? sel_hot : '0;
    assign u_out_ack = (state == WAIT) ? (u_out_stb & sel_hot) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sel     <= '0;
            p1      <= 1'b0;
            p2      <= 1'b0;
            cnt     <= '0;
            u_in1   <= '0;
            u_in2   <= '0;
            out     <= '0;
            out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_stb) begin
                        sel   <= op;
                        u_in1 <= in1;
                        u_in2 <= in2;
                        cnt   <= '0;
                        if (|op_hot) begin
                            state <= SEND;
                            p1    <= 1'b1;
                            p2    <= 1'b1;
                        end else begin
                            state   <= RESP;
                            out     <= '0;
                            out_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // Only a captured result counts as completion, so an operand
                    // ack landing on the limit edge does not rescue the transaction.
                    if (wd_hit) begin
                        state   <= RESP;
                        p1      <= 1'b0;
                        p2      <= 1'b0;
                        out     <= '0;
                        out_err <= 1'b1;
                    end else begin
                        if (TIMEOUT != 0) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (ack1) begin
                            p1 <= 1'b0;
                        end
                        if (ack2) begin
                            p2 <= 1'b0;
                        end
                        if ((!p1 || ack1) && (!p2 || ack2)) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A result arriving on the limit edge still wins.
                    if (res_vld) begin
                        state   <= RESP;
                        out     <= unit_res;
                        out_err <= 1'b0;
                    end else if (wd_hit) begin
                        state   <= RESP;
                        out     <= '0;
                        out_err <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (out_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_dispatcher.md
# fpu_dispatcher

Parametrised successor to the single-unit FPU controller: accepts one floating-point request (op code plus two operands) over a strobe/acknowledge handshake, latches it, and dispatches it to one of `NUM_UNITS` functional units (adder, multiplier, divider, converters, comparators). It returns that unit's result over an output strobe/acknowledge handshake. It sits between the core's execute stage and the FPU unit array. Op-code latching, illegal-op rejection and a watchdog timeout are new relative to the previous controller.

## Interface
- `WIDTH`, 32: operand and result width.
- `NUM_UNITS`, 9: number of attached units; op code n selects unit n.
- `OP_W`, 4: op code width.
- `TIMEOUT`, 1023: watchdog limit in cycles; 0 disables the watchdog.

- `clk`  in  1: single clock; all state is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `op`  in  OP_W: unit select, sampled only at accept.
- `in1`, `in2`  in  WIDTH: operands, sampled only at accept.
- `in_stb`  in  1: request valid.
- `in_ack`  out  1: combinational; `state==IDLE && in_stb`.
- `out`  out  WIDTH: result register.
- `out_err`  out  1: illegal op or timeout.
- `out_stb`  out  1: result valid.
- `out_ack`  in  1: result consumed.
- `busy`  out  1: state != IDLE.
- `u_in1`, `u_in2`  out  WIDTH: latched operands, broadcast to all units.
- `u_in1_stb`, `u_in2_stb`  out  NUM_UNITS: one-hot operand strobes.
- `u_in1_ack`, `u_in2_ack`  in  NUM_UNITS: unit operand acknowledges.
- `u_out`  in  NUM_UNITS*WIDTH: unit results; unit k occupies bits [k*WIDTH +: WIDTH].
- `u_out_stb`  in  NUM_UNITS: unit result valid.
- `u_out_ack`  out  NUM_UNITS: combinational; `state==WAIT && u_out_stb[sel]`, driven on bit `sel` only.

## Operation
- States: IDLE, SEND, WAIT, RESP.
- **IDLE:** an edge with `in_stb=1` is the accept edge. At that edge the block latches `op` into `sel` and the operands into `u_in1`/`u_in2`, and clears the watchdog counter.
  - If `sel < NUM_UNITS`, go to SEND and set both pending flags `p1`/`p2`.
  - Otherwise go to RESP with `out=0`, `out_err=1`.
- **SEND:**
  - `u_in1_stb[sel] = p1` and `u_in2_stb[sel] = p2`; all other strobe bits are 0.
  - An edge that samples `u_in1_ack[sel]=1` clears `p1`. The same rule applies to `p2` with `u_in2_ack[sel]`. Both may clear on the same edge.
  - A cleared strobe is never re-asserted within the transaction.
  - When both flags are clear, go to WAIT.
- **WAIT:**
  - `u_out_ack[sel]` follows `u_out_stb[sel]`.
  - On an edge with `u_out_stb[sel]=1`: capture `u_out[sel]` into `out`, set `out_err=0`, go to RESP.
- **RESP:**
  - `out_stb=1`; `out` and `out_err` are held stable.
  - An edge with `out_ack=1` moves to IDLE.
- **Watchdog:**
  - The counter is `$clog2(TIMEOUT+1)` bits wide and increments each cycle in SEND and WAIT.
  - An edge in SEND or WAIT with count==TIMEOUT and no completion on that edge: drop all unit strobes, go to RESP with `out=0`, `out_err=1`. The hung unit is recovered only by reset.
  - Completion wins over timeout on the same edge.
- Changes to `op`, `in1` or `in2` after the accept edge have no effect on the transaction in flight.
- `busy` is 1 in SEND, WAIT and RESP.

## Timing
- Reset (asynchronous): state IDLE.
  - `out=0`, `out_err=0`, `out_stb=0`, `busy=0`.
  - `u_in1=0`, `u_in2=0`.
  - All `u_*_stb` and `u_*_ack` bits are 0 immediately, without waiting for a clock edge.
- Reset mid-transaction aborts it. The first edge after reset release can accept a new request.
- Valid request, accepted at edge T0:
  - Unit strobes go high in the cycle after T0.
  - With both operand acks at T1 and `u_out_stb` at T2, `out_stb` is high from the cycle after T2.
  - Minimum latency is 3 cycles from the accept edge to `out_stb`, plus unit stall cycles.
- Illegal op: `out_stb` is high in the cycle after the accept edge; no unit strobe is ever asserted.
- `in_ack` is 0 whenever `busy=1`. Back-to-back requests:
  - The `out_ack` edge returns the block to IDLE.
  - The earliest next accept is the following edge.

## Test plan
- Add: `op=0`, `in1=0x3F800000`, `in2=0x40000000`; unit-0 model replies `0x40400000` after 4 cycles.
  - Expect `out=0x40400000`, `out_err=0`, `out_stb` exactly 3+4 cycles after the accept edge.
  - Expect only strobe bit 0 ever asserted.
- Staggered acks: unit 2 acks in1 at SEND cycle 1 and in2 at SEND cycle 4.
  - Expect `u_in1_stb[2]` to fall after its ack and stay low.
  - Expect `u_in2_stb[2]` high for 4 cycles.
  - Expect `op` changed to 5 after accept to have no effect.
- Illegal op: `op=4'hF` with `NUM_UNITS=9`.
  - Expect `out_stb=1` one cycle after accept, with `out=0`, `out_err=1`.
  - Expect all `u_*_stb` bits to remain 0.
- Timeout: `TIMEOUT=8`, unit 3 never acks.
  - Expect RESP with `out_err=1`, `out=0` on the 9th edge after accept.
  - Expect strobes to drop on that same edge.
- Back-pressure: `out_ack` held low for 5 cycles while `in_stb=1`.
  - Expect `out` and `out_stb` stable and `in_ack=0` throughout.
  - Expect the next request accepted on the edge after the `out_ack` edge.
- Reset asserted mid-WAIT (between edges).
  - Expect all outputs 0 before the next edge.
  - After release, expect a fresh add to complete correctly.
